// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode/state types shared by shift_reg_univ and shift_reg_core.
// SHIFT_REG_ROTATE_EN promotes ROL/ROR to real shift modes.
package shift_reg_pkg;
  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    LOAD = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5
  } mode_e;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;
  function automatic logic is_shift(input mode_e m);
`ifdef SHIFT_REG_ROTATE_EN
    return m inside {SHL, SHR, ROL, ROR};
`else
    return m inside {SHL, SHR};
`endif
  endfunction
endpackage

// File: rtl/shift_reg_core.sv
// shift_reg_core: combinational next-q mux; unknown or disabled codes hold.
module shift_reg_core
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pd,
  output logic [WIDTH-1:0] q_nxt
);
  assign q_nxt = mode == SHL  ? {q[WIDTH-2:0], sin_r} :
                 mode == SHR  ? {sin_l, q[WIDTH-1:1]} :
                 mode == LOAD ? pd :
`ifdef SHIFT_REG_ROTATE_EN
                 mode == ROL  ? {q[WIDTH-2:0], q[WIDTH-1]} :
                 mode == ROR  ? {q[0], q[WIDTH-1:1]} :
`endif
                 q;
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with counted burst shift and busy/done handshake.
// Optional ROL/ROR modes via SHIFT_REG_ROTATE_EN; NEG_EDGE picks the active clock edge.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               NEG_EDGE  = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pre,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pd,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);
  state_e st, st_n;
  mode_e mode_l, mode_l_n, op;
  logic [WIDTH-1:0] q_n, q_core;
  logic [CNT_W-1:0] rem, rem_n;
  logic done_n;
  assign op = st == BURST ? mode_l : mode_e'(mode);
  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .q(q), .mode(op), .sin_l(sin_l), .sin_r(sin_r), .pd(pd), .q_nxt(q_core)
  );
  always_comb begin
    st_n = st;
    q_n = q;
    rem_n = rem;
    mode_l_n = mode_l;
    done_n = 1'b0;
    if (pre) begin
      st_n = IDLE;
      q_n = '1;
      rem_n = '0;
    end else if (st == BURST) begin
      q_n = q_core;
      rem_n = rem - CNT_W'(1);
      st_n = rem == CNT_W'(1) ? IDLE : BURST;
      done_n = rem == CNT_W'(1);
    end else if (start) begin
      if (cnt != '0 && is_shift(mode_e'(mode))) begin
        st_n = BURST;
        rem_n = cnt;
        mode_l_n = mode_e'(mode);
      end else begin
        done_n = 1'b1;
      end
    end else begin
      q_n = q_core;
    end
  end
  // Only one of these register banks elaborates, chosen by NEG_EDGE.
  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge clk or posedge clr)
      if (clr) begin
        q <= RESET_VAL;
        st <= IDLE;
        rem <= '0;
        mode_l <= HOLD;
        done <= 1'b0;
      end else begin
        q <= q_n;
        st <= st_n;
        rem <= rem_n;
        mode_l <= mode_l_n;
        done <= done_n;
      end
  end else begin : g_pos
    always_ff @(posedge clk or posedge clr)
      if (clr) begin
        q <= RESET_VAL;
        st <= IDLE;
        rem <= '0;
        mode_l <= HOLD;
        done <= 1'b0;
      end else begin
        q <= q_n;
        st <= st_n;
        rem <= rem_n;
        mode_l <= mode_l_n;
        done <= done_n;
      end
  end
  assign busy = st == BURST;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: scoreboard bench driving rising- and falling-edge instances in turn.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;
  typedef struct packed {logic [7:0] q; logic busy; logic done;} exp_t;
  logic clk = 1'b0, clr = 1'b1, pre = 1'b0, sin_l = 1'b0, sin_r = 1'b0, start = 1'b0, sel = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] pd = 8'h00;
  logic [3:0] cnt = 4'd0;
  logic [7:0] q0, q1, q_s;
  logic sl0, sr0, b0, d0, sl1, sr1, b1, d1, sl_s, sr_s, b_s, d_s;
  int checks = 0, errors = 0;
  exp_t sb[$];
  string tags[$];
  always #5 clk = ~clk;
  shift_reg_univ #(.NEG_EDGE(1'b0)) dut_p (
    .clk(clk), .clr(clr), .pre(pre), .mode(mode), .sin_l(sin_l), .sin_r(sin_r), .pd(pd),
    .start(start), .cnt(cnt), .q(q0), .sout_l(sl0), .sout_r(sr0), .busy(b0), .done(d0)
  );
  shift_reg_univ #(.NEG_EDGE(1'b1)) dut_n (
    .clk(clk), .clr(clr), .pre(pre), .mode(mode), .sin_l(sin_l), .sin_r(sin_r), .pd(pd),
    .start(start), .cnt(cnt), .q(q1), .sout_l(sl1), .sout_r(sr1), .busy(b1), .done(d1)
  );
  assign q_s = sel ? q1 : q0;
  assign sl_s = sel ? sl1 : sl0;
  assign sr_s = sel ? sr1 : sr0;
  assign b_s = sel ? b1 : b0;
  assign d_s = sel ? d1 : d0;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got %h exp %h", tag, sel, got, exp);
    end
  endtask
  task automatic act_edge;
    if (sel) @(negedge clk);
    else @(posedge clk);
    #1;
  endtask
  task automatic idle_edge;
    if (sel) @(posedge clk);
    else @(negedge clk);
    #1;
  endtask
  task automatic drv(input logic [2:0] m, input logic [7:0] d, input logic s, input logic [3:0] c,
                     input logic sl, input logic sr, input logic p);
    mode = m; pd = d; start = s; cnt = c; sin_l = sl; sin_r = sr; pre = p;
  endtask
  task automatic step(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    string t;
    sb.push_back('{eq, eb, ed});
    tags.push_back(tag);
    act_edge();
    e = sb.pop_front();
    t = tags.pop_front();
    chk({t, ".q"}, q_s, e.q);
    chk({t, ".busy"}, {7'b0, b_s}, {7'b0, e.busy});
    chk({t, ".done"}, {7'b0, d_s}, {7'b0, e.done});
  endtask
  task automatic async_clr_check(input string tag);
    clr = 1'b1;
    #1;
    chk({tag, ".q"}, q_s, 8'h00);
    chk({tag, ".busy"}, {7'b0, b_s}, 8'h00);
    chk({tag, ".done"}, {7'b0, d_s}, 8'h00);
    clr = 1'b0;
  endtask
  task automatic run;
    act_edge();
    drv(HOLD, 8'h00, 0, 0, 0, 0, 0);
    async_clr_check("reset");
    // value must appear only on the selected edge
    drv(LOAD, 8'hA5, 0, 0, 0, 0, 0);
    idle_edge();
    chk("edge_sel", q_s, 8'h00);
    step("load_a5", 8'hA5, 0, 0);
    drv(SHL, 8'h00, 0, 0, 0, 1, 0);
    step("shl", 8'h4B, 0, 0);
    drv(SHR, 8'h00, 0, 0, 0, 0, 0);
    step("shr", 8'h25, 0, 0);
    chk("sout_r", {7'b0, sr_s}, 8'h01);
    chk("sout_l", {7'b0, sl_s}, 8'h00);
    drv(HOLD, 8'hFF, 0, 0, 1, 1, 0);
    step("hold", 8'h25, 0, 0);
    // burst SHR x3 with mode/start noise while busy
    drv(LOAD, 8'h81, 0, 0, 0, 0, 0);
    step("load_81", 8'h81, 0, 0);
    drv(SHR, 8'h00, 1, 3, 0, 0, 0);
    step("bst_go", 8'h81, 1, 0);
    drv(SHL, 8'hFF, 1, 1, 0, 1, 0);
    step("bst_1", 8'h40, 1, 0);
    step("bst_2", 8'h20, 1, 0);
    step("bst_3", 8'h10, 0, 1);
    drv(HOLD, 8'hFF, 1, 0, 0, 0, 0);
    step("zero_cnt", 8'h10, 0, 1);
    drv(LOAD, 8'hFF, 1, 2, 0, 0, 0);
    step("nonshift", 8'h10, 0, 1);
    drv(HOLD, 8'h00, 0, 0, 0, 0, 0);
    step("idle", 8'h10, 0, 0);
    // preset aborts a burst without done
    drv(SHL, 8'h00, 1, 4, 0, 0, 0);
    step("pb_go", 8'h10, 1, 0);
    drv(HOLD, 8'h00, 0, 0, 0, 0, 0);
    step("pb_1", 8'h20, 1, 0);
    drv(HOLD, 8'h00, 0, 0, 0, 0, 1);
    step("pre", 8'hFF, 0, 0);
    drv(HOLD, 8'h00, 0, 0, 0, 0, 0);
    step("post_pre", 8'hFF, 0, 0);
    drv(HOLD, 8'h00, 0, 0, 0, 0, 1);
    clr = 1'b1;
    step("pre_clr", 8'h00, 0, 0);
    clr = 1'b0;
    // clear mid-burst after two shifts
    drv(LOAD, 8'h81, 0, 0, 0, 0, 0);
    step("cb_load", 8'h81, 0, 0);
    drv(SHR, 8'h00, 1, 5, 1, 0, 0);
    step("cb_go", 8'h81, 1, 0);
    drv(HOLD, 8'h00, 0, 0, 1, 0, 0);
    step("cb_1", 8'hC0, 1, 0);
    step("cb_2", 8'hE0, 1, 0);
    async_clr_check("mid_clr");
    drv(HOLD, 8'h00, 0, 0, 0, 0, 0);
    step("post_clr", 8'h00, 0, 0);
    drv(LOAD, 8'h81, 0, 0, 0, 0, 0);
    step("rot_load", 8'h81, 0, 0);
`ifdef SHIFT_REG_ROTATE_EN
    drv(3'd4, 8'h00, 0, 0, 0, 0, 0);
    step("rol", 8'h03, 0, 0);
    drv(3'd5, 8'h00, 1, 2, 0, 0, 0);
    step("ror_go", 8'h03, 1, 0);
    drv(HOLD, 8'h00, 0, 0, 0, 0, 0);
    step("ror_1", 8'h81, 1, 0);
    step("ror_2", 8'hC0, 0, 1);
`else
    drv(3'd4, 8'h00, 0, 0, 1, 1, 0);
    step("m4_hold", 8'h81, 0, 0);
    drv(3'd4, 8'h00, 1, 2, 0, 0, 0);
    step("m4_start", 8'h81, 0, 1);
    drv(HOLD, 8'h00, 0, 0, 0, 0, 0);
    step("m4_idle", 8'h81, 0, 0);
`endif
  endtask
  initial begin
    sel = 1'b0;
    run();
    sel = 1'b1;
    run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
